// File: rtl/denise_clx_arbiter_if.sv
// Host snapshot handshake between denise_clx_arbiter and an OSD/monitor reader.
// The reader drives a level request (4-phase). The arbiter returns an ack and
// the latched frame snapshot, which holds steady while the ack is high.
interface denise_clx_arbiter_if #(
  parameter int CNT_W = 8
) ();

  logic                host_req;
  logic                host_clr;
  logic                host_ack;
  logic [CNT_W+15:0]   host_data;

  modport master (
    output host_req,
    output host_clr,
    input  host_ack,
    input  host_data
  );

  modport slave (
    input  host_req,
    input  host_clr,
    output host_ack,
    output host_data
  );

endinterface

// File: rtl/denise_clx_arbiter.sv
// Denise CLXDAT sequencer.
// - Accumulates collision bits into sticky CLXDAT.
// - Serves the custom-chip bus read, clearing CLXDAT once per read burst as the
//   burst ends.
// - Takes a snapshot once per frame for a non-destructive host reader.
// - Counts collision pixels per frame with a saturating counter.
module denise_clx_arbiter #(
  parameter int CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clk7_en,
  input  logic [14:0]          cl_in,
  input  logic [7:0]           reg_address_in,
  output logic [15:0]          data_out,
  input  logic                 vbl,
  denise_clx_arbiter_if.slave  host,
  output logic                 clx_any
);

  typedef enum logic {C_IDLE = 1'b0, C_RD = 1'b1} cpu_state_t;
  typedef enum logic {H_IDLE = 1'b0, H_ACK = 1'b1} host_state_t;

  // Increment by one unless the counter is already at its maximum.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic inc);
    if (inc && (v != {CNT_W{1'b1}})) begin
      sat_inc = v + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      sat_inc = v;
    end
  endfunction

  cpu_state_t        c_state_r, c_state_nxt_s;
  host_state_t       h_state_r, h_state_nxt_s;
  logic [14:0]       clxdat_r, clxdat_nxt_s;
  logic [14:0]       frame_clx_r, frame_clx_nxt_s;
  logic              frame_valid_r, frame_valid_nxt_s;
  logic [CNT_W-1:0]  cnt_r, cnt_nxt_s;
  logic [CNT_W-1:0]  frame_cnt_r, frame_cnt_nxt_s;
  logic [CNT_W+15:0] host_data_r, host_data_nxt_s;
  logic              host_ack_r, host_ack_nxt_s;
  logic              clx_any_r;
  logic              rd_s;
  logic              clear_s;
  logic [CNT_W-1:0]  cnt_inc_s;

  assign rd_s      = (reg_address_in == 8'h07);
  assign cnt_inc_s = sat_inc(cnt_r, |cl_in);

  // Bus read mux: the top bit always reads as one, as on the original chip.
  assign data_out = rd_s ? {1'b1, clxdat_r} : 16'h0000;

  assign host.host_ack  = host_ack_r;
  assign host.host_data = host_data_r;
  assign clx_any        = clx_any_r;

  // Next-state logic for both FSMs and all datapath registers.
  always_comb begin
    c_state_nxt_s     = c_state_r;
    h_state_nxt_s     = h_state_r;
    clxdat_nxt_s      = clxdat_r;
    frame_clx_nxt_s   = frame_clx_r;
    frame_valid_nxt_s = frame_valid_r;
    cnt_nxt_s         = cnt_r;
    frame_cnt_nxt_s   = frame_cnt_r;
    host_data_nxt_s   = host_data_r;
    host_ack_nxt_s    = host_ack_r;
    clear_s           = 1'b0;
    if (clk7_en) begin
      // The clear lands on the first cycle after a read burst ends, so the
      // CPU has sampled the final value before it is discarded.
      case (c_state_r)
        C_IDLE: begin
          if (rd_s) begin
            c_state_nxt_s = C_RD;
          end else begin
            c_state_nxt_s = C_IDLE;
          end
        end
        C_RD: begin
          if (rd_s) begin
            c_state_nxt_s = C_RD;
          end else begin
            c_state_nxt_s = C_IDLE;
            clear_s       = 1'b1;
          end
        end
        default: begin
          c_state_nxt_s = C_IDLE;
        end
      endcase

      if (clear_s) begin
        clxdat_nxt_s = 15'h0000;
      end else begin
        clxdat_nxt_s = clxdat_r | cl_in;
      end

      // The frame snapshot takes the pre-clear value, including this cycle's
      // pixel.
      if (vbl) begin
        frame_clx_nxt_s   = clxdat_r | cl_in;
        frame_cnt_nxt_s   = cnt_inc_s;
        frame_valid_nxt_s = 1'b1;
        cnt_nxt_s         = {CNT_W{1'b0}};
      end else begin
        cnt_nxt_s         = cnt_inc_s;
      end

      // Acceptance is deferred in a vbl cycle, so the host sees the new
      // snapshot.
      case (h_state_r)
        H_IDLE: begin
          if (host.host_req && !vbl) begin
            host_data_nxt_s = {frame_cnt_r, frame_valid_r, frame_clx_r};
            host_ack_nxt_s  = 1'b1;
            h_state_nxt_s   = H_ACK;
            if (host.host_clr) begin
              frame_valid_nxt_s = 1'b0;
            end else begin
              frame_valid_nxt_s = frame_valid_r;
            end
          end else begin
            h_state_nxt_s = H_IDLE;
          end
        end
        H_ACK: begin
          if (host.host_req) begin
            h_state_nxt_s = H_ACK;
          end else begin
            host_ack_nxt_s = 1'b0;
            h_state_nxt_s  = H_IDLE;
          end
        end
        default: begin
          host_ack_nxt_s = 1'b0;
          h_state_nxt_s  = H_IDLE;
        end
      endcase
    end else begin
      c_state_nxt_s = c_state_r;
    end
  end

  // State and datapath registers. clx_any follows the next CLXDAT value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      c_state_r     <= C_IDLE;
      h_state_r     <= H_IDLE;
      clxdat_r      <= 15'h0000;
      frame_clx_r   <= 15'h0000;
      frame_valid_r <= 1'b0;
      cnt_r         <= {CNT_W{1'b0}};
      frame_cnt_r   <= {CNT_W{1'b0}};
      host_data_r   <= {(CNT_W+16){1'b0}};
      host_ack_r    <= 1'b0;
      clx_any_r     <= 1'b0;
    end else begin
      c_state_r     <= c_state_nxt_s;
      h_state_r     <= h_state_nxt_s;
      clxdat_r      <= clxdat_nxt_s;
      frame_clx_r   <= frame_clx_nxt_s;
      frame_valid_r <= frame_valid_nxt_s;
      cnt_r         <= cnt_nxt_s;
      frame_cnt_r   <= frame_cnt_nxt_s;
      host_data_r   <= host_data_nxt_s;
      host_ack_r    <= host_ack_nxt_s;
      clx_any_r     <= |clxdat_nxt_s;
    end
  end

endmodule

// File: tb/tb_denise_clx_arbiter.sv
// Self-checking bench for denise_clx_arbiter. Expected bus-read and host
// snapshot values are queued when stimulus is applied and popped when the DUT
// presents them.
module tb_denise_clx_arbiter;

  localparam int CNT_W = 8;

  logic              clk;
  logic              reset;
  logic              clk7_en;
  logic [14:0]       cl_in;
  logic [7:0]        reg_address_in;
  logic [15:0]       data_out;
  logic              vbl;
  logic              clx_any;

  denise_clx_arbiter_if #(.CNT_W(CNT_W)) hif ();

  denise_clx_arbiter #(.CNT_W(CNT_W)) dut (
    .clk            (clk),
    .reset          (reset),
    .clk7_en        (clk7_en),
    .cl_in          (cl_in),
    .reg_address_in (reg_address_in),
    .data_out       (data_out),
    .vbl            (vbl),
    .host           (hif),
    .clx_any        (clx_any)
  );

  int n_cmp;
  int n_err;
  logic [15:0]       exp_cpu_q [$];
  logic [CNT_W+15:0] exp_host_q [$];
  logic [15:0]       e16;
  logic [CNT_W+15:0] eh;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One enabled edge followed by one disabled edge; returns 1 time unit after the last edge.
  task automatic tick();
    clk7_en = 1'b1;
    @(posedge clk);
    #1;
    clk7_en = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #3;
    n_cmp++; if (clx_any !== 1'b0) begin n_err++; $display("FAIL rst_clx_any: got %b expected 0", clx_any); end
    n_cmp++; if (hif.host_ack !== 1'b0) begin n_err++; $display("FAIL rst_ack: got %b expected 0", hif.host_ack); end
    n_cmp++; if (hif.host_data !== 24'h000000) begin n_err++; $display("FAIL rst_host_data: got %h expected 000000", hif.host_data); end
    n_cmp++; if (data_out !== 16'h0000) begin n_err++; $display("FAIL rst_no_rd: got %h expected 0000", data_out); end
    reg_address_in = 8'h07;
    exp_cpu_q.push_back(16'h8000);
    #1;
    e16 = exp_cpu_q.pop_front();
    n_cmp++; if (data_out !== e16) begin n_err++; $display("FAIL rst_rd: got %h expected %h", data_out, e16); end
    reg_address_in = 8'h00;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_accumulate_clear();
    cl_in = 15'h0001;
    tick();
    cl_in = 15'h0000;
    n_cmp++; if (clx_any !== 1'b1) begin n_err++; $display("FAIL acc_clx_any: got %b expected 1", clx_any); end
    reg_address_in = 8'h07;
    exp_cpu_q.push_back(16'h8001);
    tick();
    e16 = exp_cpu_q.pop_front();
    n_cmp++; if (data_out !== e16) begin n_err++; $display("FAIL acc_rd: got %h expected %h", data_out, e16); end
    reg_address_in = 8'h00;
    tick();
    n_cmp++; if (clx_any !== 1'b0) begin n_err++; $display("FAIL clr_clx_any: got %b expected 0", clx_any); end
    reg_address_in = 8'h07;
    exp_cpu_q.push_back(16'h8000);
    #1;
    e16 = exp_cpu_q.pop_front();
    n_cmp++; if (data_out !== e16) begin n_err++; $display("FAIL clr_rd: got %h expected %h", data_out, e16); end
    reg_address_in = 8'h00;
  endtask

  task automatic test_burst();
    reg_address_in = 8'h07;
    for (int i = 0; i < 5; i++) begin
      cl_in = (i == 2) ? 15'h0200 : 15'h0000;
      exp_cpu_q.push_back((i >= 2) ? 16'h8200 : 16'h8000);
      tick();
      e16 = exp_cpu_q.pop_front();
      n_cmp++; if (data_out !== e16) begin n_err++; $display("FAIL burst_rd%0d: got %h expected %h", i, data_out, e16); end
    end
    // Pixel arriving in the clear cycle is discarded.
    reg_address_in = 8'h00;
    cl_in = 15'h0001;
    tick();
    cl_in = 15'h0000;
    n_cmp++; if (clx_any !== 1'b0) begin n_err++; $display("FAIL burst_clx_any: got %b expected 0", clx_any); end
    reg_address_in = 8'h07;
    exp_cpu_q.push_back(16'h8000);
    #1;
    e16 = exp_cpu_q.pop_front();
    n_cmp++; if (data_out !== e16) begin n_err++; $display("FAIL burst_after_clr: got %h expected %h", data_out, e16); end
    reg_address_in = 8'h00;
  endtask

  task automatic test_saturate();
    cl_in = 15'h0100;
    for (int i = 0; i < 300; i++) tick();
    cl_in = 15'h0000;
    vbl = 1'b1;
    tick();
    vbl = 1'b0;
    exp_host_q.push_back({8'hFF, 1'b1, 15'h0100});
    hif.host_req = 1'b1;
    tick();
    n_cmp++; if (hif.host_ack !== 1'b1) begin n_err++; $display("FAIL sat_ack: got %b expected 1", hif.host_ack); end
    eh = exp_host_q.pop_front();
    n_cmp++; if (hif.host_data !== eh) begin n_err++; $display("FAIL sat_data: got %h expected %h", hif.host_data, eh); end
    hif.host_req = 1'b0;
    tick();
    n_cmp++; if (hif.host_ack !== 1'b0) begin n_err++; $display("FAIL sat_ack_fall: got %b expected 0", hif.host_ack); end
    // Counter was cleared by the snapshot: an idle frame reports zero.
    vbl = 1'b1;
    tick();
    vbl = 1'b0;
    exp_host_q.push_back({8'h00, 1'b1, 15'h0100});
    hif.host_req = 1'b1;
    tick();
    eh = exp_host_q.pop_front();
    n_cmp++; if (hif.host_data !== eh) begin n_err++; $display("FAIL cnt_zero_data: got %h expected %h", hif.host_data, eh); end
    hif.host_req = 1'b0;
    tick();
  endtask

  task automatic test_vbl_clear();
    reg_address_in = 8'h07;
    tick();
    reg_address_in = 8'h00;
    tick();
    cl_in = 15'h0010;
    tick();
    cl_in = 15'h0000;
    reg_address_in = 8'h07;
    tick();
    reg_address_in = 8'h00;
    cl_in = 15'h0004;
    vbl = 1'b1;
    tick();
    vbl = 1'b0;
    cl_in = 15'h0000;
    n_cmp++; if (clx_any !== 1'b0) begin n_err++; $display("FAIL vclr_clx_any: got %b expected 0", clx_any); end
    reg_address_in = 8'h07;
    exp_cpu_q.push_back(16'h8000);
    #1;
    e16 = exp_cpu_q.pop_front();
    n_cmp++; if (data_out !== e16) begin n_err++; $display("FAIL vclr_rd: got %h expected %h", data_out, e16); end
    reg_address_in = 8'h00;
    exp_host_q.push_back({8'h02, 1'b1, 15'h0014});
    hif.host_req = 1'b1;
    tick();
    eh = exp_host_q.pop_front();
    n_cmp++; if (hif.host_data !== eh) begin n_err++; $display("FAIL vclr_data: got %h expected %h", hif.host_data, eh); end
    hif.host_req = 1'b0;
    tick();
  endtask

  task automatic test_req_vbl();
    cl_in = 15'h0020;
    tick();
    cl_in = 15'h0000;
    hif.host_req = 1'b1;
    hif.host_clr = 1'b1;
    vbl = 1'b1;
    tick();
    vbl = 1'b0;
    n_cmp++; if (hif.host_ack !== 1'b0) begin n_err++; $display("FAIL rv_defer: got %b expected 0", hif.host_ack); end
    exp_host_q.push_back({8'h01, 1'b1, 15'h0020});
    tick();
    n_cmp++; if (hif.host_ack !== 1'b1) begin n_err++; $display("FAIL rv_ack: got %b expected 1", hif.host_ack); end
    eh = exp_host_q.pop_front();
    n_cmp++; if (hif.host_data !== eh) begin n_err++; $display("FAIL rv_data: got %h expected %h", hif.host_data, eh); end
    hif.host_req = 1'b0;
    hif.host_clr = 1'b0;
    tick();
    n_cmp++; if (hif.host_ack !== 1'b0) begin n_err++; $display("FAIL rv_ack_fall: got %b expected 0", hif.host_ack); end
    exp_host_q.push_back({8'h01, 1'b0, 15'h0020});
    exp_host_q.push_back({8'h01, 1'b0, 15'h0020});
    hif.host_req = 1'b1;
    tick();
    eh = exp_host_q.pop_front();
    n_cmp++; if (hif.host_data !== eh) begin n_err++; $display("FAIL rv_cleared: got %h expected %h", hif.host_data, eh); end
    // A snapshot during H_ACK must not disturb the latched data.
    cl_in = 15'h0040;
    vbl = 1'b1;
    tick();
    vbl = 1'b0;
    cl_in = 15'h0000;
    n_cmp++; if (hif.host_ack !== 1'b1) begin n_err++; $display("FAIL rv_hold_ack: got %b expected 1", hif.host_ack); end
    eh = exp_host_q.pop_front();
    n_cmp++; if (hif.host_data !== eh) begin n_err++; $display("FAIL rv_hold_data: got %h expected %h", hif.host_data, eh); end
    hif.host_req = 1'b0;
    tick();
  endtask

  task automatic test_enable_gate();
    clk7_en = 1'b0;
    cl_in = 15'h7FFF;
    vbl = 1'b1;
    hif.host_req = 1'b1;
    reg_address_in = 8'h07;
    exp_cpu_q.push_back(16'h8060);
    repeat (3) @(posedge clk);
    #1;
    e16 = exp_cpu_q.pop_front();
    n_cmp++; if (data_out !== e16) begin n_err++; $display("FAIL gate_rd: got %h expected %h", data_out, e16); end
    n_cmp++; if (hif.host_ack !== 1'b0) begin n_err++; $display("FAIL gate_ack: got %b expected 0", hif.host_ack); end
    cl_in = 15'h0000;
    vbl = 1'b0;
    hif.host_req = 1'b0;
    reg_address_in = 8'h00;
  endtask

  task automatic test_reset_mid();
    cl_in = 15'h7FFF;
    tick();
    cl_in = 15'h0000;
    hif.host_req = 1'b1;
    tick();
    n_cmp++; if (hif.host_ack !== 1'b1) begin n_err++; $display("FAIL rm_ack: got %b expected 1", hif.host_ack); end
    reg_address_in = 8'h07;
    exp_cpu_q.push_back(16'hFFFF);
    tick();
    e16 = exp_cpu_q.pop_front();
    n_cmp++; if (data_out !== e16) begin n_err++; $display("FAIL rm_rd_full: got %h expected %h", data_out, e16); end
    #1;
    reset = 1'b1;
    exp_cpu_q.push_back(16'h8000);
    #1;
    n_cmp++; if (hif.host_ack !== 1'b0) begin n_err++; $display("FAIL rm_ack_rst: got %b expected 0", hif.host_ack); end
    n_cmp++; if (hif.host_data !== 24'h000000) begin n_err++; $display("FAIL rm_data_rst: got %h expected 000000", hif.host_data); end
    n_cmp++; if (clx_any !== 1'b0) begin n_err++; $display("FAIL rm_clx_any: got %b expected 0", clx_any); end
    e16 = exp_cpu_q.pop_front();
    n_cmp++; if (data_out !== e16) begin n_err++; $display("FAIL rm_rd_rst: got %h expected %h", data_out, e16); end
    hif.host_req = 1'b0;
    reg_address_in = 8'h00;
    @(negedge clk);
    reset = 1'b0;
    tick();
    n_cmp++; if (hif.host_ack !== 1'b0) begin n_err++; $display("FAIL rm_ack_after: got %b expected 0", hif.host_ack); end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b1;
    clk7_en = 1'b0;
    cl_in = 15'h0000;
    reg_address_in = 8'h00;
    vbl = 1'b0;
    hif.host_req = 1'b0;
    hif.host_clr = 1'b0;
    test_reset();
    test_accumulate_clear();
    test_burst();
    test_saturate();
    test_vbl_clear();
    test_req_vbl();
    test_enable_gate();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
